// File: rtl/rf_pkg.sv
// Shared types and helpers for the register-file reader.
// Contents:
//   DEFAULT_WORD_LENGTH / DEFAULT_ADDR_WIDTH - default widths
//   word_t / addr_t                          - word and address types at default widths
//   is_zero_addr                             - true for the hard-wired zero register
package rf_pkg;

  localparam int unsigned DEFAULT_WORD_LENGTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH  = 5;

  typedef logic [DEFAULT_WORD_LENGTH-1:0] word_t;
  typedef logic [DEFAULT_ADDR_WIDTH-1:0]  addr_t;

  // Callers size-cast their address to 32 bits so any ADDR_WIDTH up to 32 works.
  function automatic logic is_zero_addr(input logic [31:0] addr);
    return (addr == 32'd0);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set when a producer reserves it and cleared
// when writeback lands. Register 0 is never busy.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   wr_en, wr_addr      - writeback clears busy
//   rsv_en, rsv_addr    - reserve sets busy (wins over a same-cycle write)
//   ra_addr, rb_addr    - lookup addresses
//   ra_busy, rb_busy    - combinational busy state (pre-update)
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  input  logic [ADDR_WIDTH-1:0] ra_addr,
  input  logic [ADDR_WIDTH-1:0] rb_addr,
  output logic                  ra_busy,
  output logic                  rb_busy
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

  logic [NUM_REGS-1:0] busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      if (wr_en && !is_zero_addr(32'(wr_addr))) begin
        busy_q[wr_addr] <= 1'b0;
      end
      // Later assignment wins: a new producer reserving in the writeback cycle stays pending.
      if (rsv_en && !is_zero_addr(32'(rsv_addr))) begin
        busy_q[rsv_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    ra_busy = busy_q[ra_addr];
    rb_busy = busy_q[rb_addr];
  end

endmodule

// File: rtl/reg_file_reader.sv
// 2-read / 1-write register file with registered read ports and busy-bit scoreboard.
// A read request at cycle T reports at T+1 either rd_valid (both operands ready) or
// rd_stall (an operand has an outstanding producer; re-issue).
// Optional macro RF_BYPASS_EN: a same-cycle write forwards its data to the read and counts
// as not busy. Without it, the read sees the pre-write contents and busy state.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data     - writeback port
//   rsv_en, rsv_addr            - reserve a register for a future write
//   rd_req, ra_addr, rb_addr    - read request
//   ra_data, rb_data            - registered operands
//   rd_valid, rd_stall          - one-cycle, mutually exclusive result flags
module reg_file_reader
  import rf_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = DEFAULT_WORD_LENGTH,
  parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [WORD_LENGTH-1:0] wr_data,
  input  logic                   rsv_en,
  input  logic [ADDR_WIDTH-1:0]  rsv_addr,
  input  logic                   rd_req,
  input  logic [ADDR_WIDTH-1:0]  ra_addr,
  input  logic [ADDR_WIDTH-1:0]  rb_addr,
  output logic [WORD_LENGTH-1:0] ra_data,
  output logic [WORD_LENGTH-1:0] rb_data,
  output logic                   rd_valid,
  output logic                   rd_stall
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

  logic [WORD_LENGTH-1:0] mem [NUM_REGS];

  logic                   ra_busy_sb, rb_busy_sb;
  logic                   ra_busy, rb_busy;
  logic [WORD_LENGTH-1:0] ra_val, rb_val;
  logic                   wr_live;

  assign wr_live = wr_en && !is_zero_addr(32'(wr_addr));

  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .ra_addr  (ra_addr),
    .rb_addr  (rb_addr),
    .ra_busy  (ra_busy_sb),
    .rb_busy  (rb_busy_sb)
  );

  // Storage. Entry 0 is never written, so it stays zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_live) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Operand selection; busy reflects state before this cycle's reserve.
  always_comb begin
    ra_val  = mem[ra_addr];
    rb_val  = mem[rb_addr];
    ra_busy = ra_busy_sb;
    rb_busy = rb_busy_sb;
`ifdef RF_BYPASS_EN
    if (wr_live && (wr_addr == ra_addr)) begin
      ra_val  = wr_data;
      ra_busy = 1'b0;
    end
    if (wr_live && (wr_addr == rb_addr)) begin
      rb_val  = wr_data;
      rb_busy = 1'b0;
    end
`else
    // Reads see the pre-write contents; wr_data is only used through storage.
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra_data  <= '0;
      rb_data  <= '0;
      rd_valid <= 1'b0;
      rd_stall <= 1'b0;
    end else begin
      rd_valid <= rd_req && !(ra_busy || rb_busy);
      rd_stall <= rd_req && (ra_busy || rb_busy);
      if (rd_req) begin
        ra_data <= ra_val;
        rb_data <= rb_val;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_reader.sv
// Self-checking bench for reg_file_reader: directed steps from the test plan followed by
// randomized traffic, all compared against a behavioural model of the register file.
module tb_reg_file_reader;

  localparam int unsigned W = 32;
  localparam int unsigned A = 5;
  localparam int unsigned N = 2 ** A;

  logic         clk = 1'b0;
  logic         rst, wr_en, rsv_en, rd_req;
  logic [A-1:0] wr_addr, rsv_addr, ra_addr, rb_addr;
  logic [W-1:0] wr_data;
  logic [W-1:0] ra_data, rb_data;
  logic         rd_valid, rd_stall;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [W-1:0] m_mem  [N];
  logic         m_busy [N];
  logic [W-1:0] e_ra, e_rb;
  logic         e_valid, e_stall;

  always #5 clk = ~clk;

  reg_file_reader #(
    .WORD_LENGTH (W),
    .ADDR_WIDTH  (A)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_req   (rd_req),
    .ra_addr  (ra_addr),
    .rb_addr  (rb_addr),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .rd_valid (rd_valid),
    .rd_stall (rd_stall)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 1'b0; rsv_en = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rsv_addr = '0; ra_addr = '0; rb_addr = '0; wr_data = '0;
  endtask

  // What a read of register a sees this cycle: {busy, value}.
  function automatic logic [W:0] model_read(input logic [A-1:0] a);
    logic [W-1:0] v;
    logic         b;
    v = (a == 0) ? '0 : m_mem[a];
    b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef RF_BYPASS_EN
    if (wr_en && wr_addr != 0 && wr_addr == a) begin
      v = wr_data;
      b = 1'b0;
    end
`endif
    return {b, v};
  endfunction

  // Advance one clock: predict outputs, update the model, then compare after the edge.
  task automatic tick();
    logic [W:0] ra_r, rb_r;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
      e_ra = '0; e_rb = '0; e_valid = 1'b0; e_stall = 1'b0;
    end else begin
      ra_r = model_read(ra_addr);
      rb_r = model_read(rb_addr);
      e_valid = rd_req && !ra_r[W] && !rb_r[W];
      e_stall = rd_req && (ra_r[W] || rb_r[W]);
      if (rd_req) begin
        e_ra = ra_r[W-1:0];
        e_rb = rb_r[W-1:0];
      end
      if (wr_en && wr_addr != 0) begin
        m_mem[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
    check("ra_data", ra_data, e_ra);
    check("rb_data", rb_data, e_rb);
    check("rd_valid", W'(rd_valid), W'(e_valid));
    check("rd_stall", W'(rd_stall), W'(e_stall));
    idle();
  endtask

  task automatic do_read(input logic [A-1:0] a, input logic [A-1:0] b);
    rd_req = 1'b1; ra_addr = a; rb_addr = b;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();

    // Read after reset: zero data, valid
    do_read(5'd3, 5'd0); tick();
    check("rst_read_ra", ra_data, 32'h0);
    check("rst_read_valid", W'(rd_valid), 32'd1);

    // Plain write then read
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; tick();
    do_read(5'd5, 5'd0); tick();
    check("r5_data", ra_data, 32'hDEADBEEF);
    check("r5_valid", W'(rd_valid), 32'd1);

    // Reserve, stall, write, re-read
    rsv_en = 1'b1; rsv_addr = 5'd7; tick();
    do_read(5'd7, 5'd0); tick();
    check("r7_stall", W'(rd_stall), 32'd1);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234; tick();
    do_read(5'd7, 5'd0); tick();
    check("r7_data", ra_data, 32'h1234);
    check("r7_valid", W'(rd_valid), 32'd1);

    // Same-cycle write and read of a busy register
    rsv_en = 1'b1; rsv_addr = 5'd9; tick();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hAA; do_read(5'd9, 5'd0); tick();
`ifdef RF_BYPASS_EN
    check("r9_bypass_data", ra_data, 32'hAA);
    check("r9_bypass_valid", W'(rd_valid), 32'd1);
`else
    check("r9_stall", W'(rd_stall), 32'd1);
    do_read(5'd9, 5'd0); tick();
    check("r9_retry_data", ra_data, 32'hAA);
    check("r9_retry_valid", W'(rd_valid), 32'd1);
`endif

    // Register 0 ignores writes and reserves
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF; rsv_en = 1'b1; rsv_addr = 5'd0; tick();
    do_read(5'd0, 5'd0); tick();
    check("r0_data", ra_data, 32'h0);
    check("r0_valid", W'(rd_valid), 32'd1);

    // Reserve wins over same-cycle write; then reset mid-stream
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h11; rsv_en = 1'b1; rsv_addr = 5'd4; tick();
    do_read(5'd4, 5'd0); tick();
    check("r4_stall", W'(rd_stall), 32'd1);
    rst = 1'b1; do_read(5'd4, 5'd5); tick();
    check("rst_mid_ra", ra_data, 32'h0);
    check("rst_mid_valid", W'(rd_valid), 32'd0);
    check("rst_mid_stall", W'(rd_stall), 32'd0);
    do_read(5'd4, 5'd0); tick();
    check("r4_after_rst", ra_data, 32'h0);
    check("r4_after_rst_valid", W'(rd_valid), 32'd1);

    // Randomized traffic on a small address window to force collisions
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 59) == 0);
      wr_en    = $urandom_range(0, 1) == 1;
      wr_addr  = A'($urandom_range(0, 7));
      wr_data  = $urandom;
      rsv_en   = $urandom_range(0, 2) == 0;
      rsv_addr = A'($urandom_range(0, 7));
      rd_req   = $urandom_range(0, 3) != 0;
      ra_addr  = A'($urandom_range(0, 7));
      rb_addr  = A'($urandom_range(0, 7));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
